// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks.
//   state_e : sequencing states of bit_serial_adder (IDLE/SHIFT/DONE).
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : arith_pkg

// File: rtl/full_adder.sv
// Single-bit full adder cell. The serial adder reuses one instance of it.
// Ports:
//   a, b  : operand bits
//   c     : carry in
//   sum   : a ^ b ^ c
//   carry : majority(a, b, c)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule : full_adder

// File: rtl/bit_serial_adder.sv
// Multi-bit unsigned adder that reuses a single full_adder cell over WIDTH
// clock cycles, LSB first, with a registered carry between cycles.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : request pulse, sampled only while idle
//   a_in     : operand A, captured when start is accepted
//   b_in     : operand B, captured when start is accepted
//   cin      : carry in, captured when start is accepted
//   busy     : high while shifting and during the done cycle
//   done     : one-cycle pulse, result valid
//   sum_out  : result, stable from done until the next accepted start
//   cout     : final carry out, same validity as sum_out
module bit_serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic fa_sum;
  logic fa_carry;

  full_adder u_full_adder (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = cin;
          sum_d   = '0;
          cnt_d   = '0;
          cout_d  = 1'b0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // The result fills from the top, so after WIDTH shifts bit 0 of the
        // operands has travelled down to sum_q[0].
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_carry;
        if (cnt_q == LAST_BIT) begin
          // Counter parks on the last index instead of wrapping.
          cout_d  = fa_carry;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Moore outputs decoded from the state register.
  assign busy    = (state_q == SHIFT) || (state_q == DONE);
  assign done    = (state_q == DONE);
  assign sum_out = sum_q;
  assign cout    = cout_q;

endmodule : bit_serial_adder
